// File: rtl/kcc_field_pkg.sv
// kcc_field_pkg
// Shared constants and encodings for the GF(2^283) field arithmetic unit.
//   FIELD_M / DIGIT_D : field degree and multiplier digit width
//   TAP_MASK          : low-order terms of f(x) = x^283 + x^12 + x^7 + x^5 + 1
//                       (x^M folds back onto these bit positions)
//   base_en_e, mode_e : encodings of the control_group3 sub-fields
//   CG_*              : bit positions of the control_group3 sub-fields
//   fsm_state_e       : sequencer states
package kcc_field_pkg;

    localparam int FIELD_M = 283;
    localparam int DIGIT_D = 16;

    // x^283 == x^12 + x^7 + x^5 + 1, so an overflow bit at x^(M+j)
    // is folded back by XORing this mask in at bit position j.
    localparam int               TAP_W    = 13;
    localparam logic [TAP_W-1:0] TAP_MASK = 13'h10A1;

    // control_group3 = {BasePtSel[8:5], Base_en[4:3], mode[2:1], en_primitive[0]}
    localparam int CG_EN_BIT   = 0;
    localparam int CG_MODE_LSB = 1;
    localparam int CG_BASE_LSB = 3;
    localparam int CG_SEL_LSB  = 5;

    typedef enum logic [1:0] {
        BASE_NONE = 2'd0,
        BASE_A    = 2'd1,
        BASE_B    = 2'd2,
        BASE_RSV  = 2'd3
    } base_en_e;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'd0,
        MODE_SQR  = 2'd1,
        MODE_NOP2 = 2'd2,
        MODE_NOP3 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/gf2m_squarer.sv
// gf2m_squarer
// Combinational squarer in GF(2^M): squaring a binary polynomial just spreads
// the coefficients to the even positions, then the upper half is reduced.
//   a  : input field element
//   sq : a^2 mod f(x)
module gf2m_squarer
    import kcc_field_pkg::*;
#(
    parameter int M = FIELD_M
) (
    input  logic [M-1:0] a,
    output logic [M-1:0] sq
);

    logic [2*M-2:0] wide;

    // Interleave with zeros, then fold overflow bits from the top down so that
    // bits pushed back above M by a fold are themselves folded later in the loop.
    always_comb begin
        wide = '0;
        for (int i = 0; i < M; i++) begin
            wide[2*i] = a[i];
        end
        for (int k = 2*M-2; k >= M; k--) begin
            if (wide[k]) begin
                wide[k] = 1'b0;
                wide[k-M +: TAP_W] = wide[k-M +: TAP_W] ^ TAP_MASK;
            end
        end
        sq = wide[M-1:0];
    end

endmodule

// File: rtl/field_arith_unit.sv
// field_arith_unit
// GF(2^M) arithmetic primitive: 8-entry register file, operand registers A/B,
// digit-serial MSD-first multiplier and a single-cycle squarer.
//   clk, rst        : clock, synchronous active-high reset
//   control_group3  : {BasePtSel[8:5], Base_en[4:3], mode[2:1], en_primitive[0]}
//   done_primitive  : level, last operation finished and written back
//   busy            : high while an operation is computing
//   ext_we/addr/din : external register-file write port (ignored while busy)
//   ext_dout        : combinational read of RF[ext_addr]
module field_arith_unit
    import kcc_field_pkg::*;
#(
    parameter int M = FIELD_M,
    parameter int D = DIGIT_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [8:0]   control_group3,
    output logic         done_primitive,
    output logic         busy,
    input  logic         ext_we,
    input  logic [2:0]   ext_addr,
    input  logic [M-1:0] ext_din,
    output logic [M-1:0] ext_dout
);

    localparam int NDIG = (M + D - 1) / D;
    localparam int PADW = NDIG * D;
    localparam int CNTW = $clog2(NDIG + 1);

    logic [2:0]     sel_addr;
    base_en_e       base_en;
    mode_e          mode_in;
    logic           en_prim;
    logic           ctrl_unused;

    fsm_state_e     state_q, state_d;
    logic [M-1:0]   rf [8];
    logic [M-1:0]   a_reg, b_reg, acc_q;
    logic [M-1:0]   acc_next, sq_out;
    logic [2:0]     dest_q;
    mode_e          mode_q;
    logic [CNTW-1:0] cnt_q;
    logic           last_cycle;
    logic [PADW-1:0] b_pad;
    logic [D-1:0]   digit;
    logic [M+D-1:0] mul_wide;

    // BasePtSel[3] only exists for compatibility with the controller's bus.
    assign sel_addr    = control_group3[CG_SEL_LSB +: 3];
    assign ctrl_unused = control_group3[CG_SEL_LSB + 3];
    assign base_en     = base_en_e'(control_group3[CG_BASE_LSB +: 2]);
    assign mode_in     = mode_e'(control_group3[CG_MODE_LSB +: 2]);
    assign en_prim     = control_group3[CG_EN_BIT];

    assign busy     = (state_q == ST_BUSY);
    assign ext_dout = rf[ext_addr];

    gf2m_squarer #(.M(M)) u_squarer (
        .a  (a_reg),
        .sq (sq_out)
    );

    // Only multiplies take more than one BUSY cycle.
    assign last_cycle = (mode_q != MODE_MUL) || (cnt_q == CNTW'(NDIG - 1));

    // One multiplier step: acc*x^D + A*digit, digits taken MSD-first from a
    // zero-padded B. Both terms overflow by fewer than D bits, so a single
    // fold pass (top down) leaves a fully reduced result.
    always_comb begin
        b_pad    = PADW'(b_reg);
        digit    = b_pad[(NDIG - 1 - int'(cnt_q)) * D +: D];
        mul_wide = {acc_q, {D{1'b0}}};
        for (int i = 0; i < D; i++) begin
            if (digit[i]) begin
                mul_wide = mul_wide ^ ({{D{1'b0}}, a_reg} << i);
            end
        end
        for (int k = M+D-1; k >= M; k--) begin
            if (mul_wide[k]) begin
                mul_wide[k] = 1'b0;
                mul_wide[k-M +: TAP_W] = mul_wide[k-M +: TAP_W] ^ TAP_MASK;
            end
        end
        acc_next = mul_wide[M-1:0];
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: DONE is held while the controller keeps en_primitive high so
    // a lingering strobe cannot retrigger the same operation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en_prim)    state_d = ST_BUSY;
            ST_BUSY: if (last_cycle) state_d = ST_DONE;
            ST_DONE: if (!en_prim)   state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Datapath: operand loads and external writes are locked out during BUSY,
    // which also makes the writeback the only register-file writer on its edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
            a_reg          <= '0;
            b_reg          <= '0;
            acc_q          <= '0;
            dest_q         <= '0;
            mode_q         <= MODE_MUL;
            cnt_q          <= '0;
            done_primitive <= 1'b0;
        end else begin
            if (state_q != ST_BUSY) begin
                if (base_en == BASE_A) a_reg <= rf[sel_addr];
                if (base_en == BASE_B) b_reg <= rf[sel_addr];
                if (ext_we)            rf[ext_addr] <= ext_din;
            end
            case (state_q)
                ST_IDLE: begin
                    if (en_prim) begin
                        mode_q         <= mode_in;
                        dest_q         <= sel_addr;
                        acc_q          <= '0;
                        cnt_q          <= '0;
                        done_primitive <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_cycle) begin
                        if (mode_q == MODE_MUL) rf[dest_q] <= acc_next;
                        if (mode_q == MODE_SQR) rf[dest_q] <= sq_out;
                        done_primitive <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_field_arith_unit.sv
// tb_field_arith_unit
// Self-checking bench for field_arith_unit. A plain shift-and-add GF(2^283)
// model plus a shadow copy of the register file predicts every result.
module tb_field_arith_unit;

    localparam int M = 283;

    logic         clk;
    logic         rst;
    logic [8:0]   cg;
    logic         done_primitive;
    logic         busy;
    logic         ext_we;
    logic [2:0]   ext_addr;
    logic [M-1:0] ext_din;
    logic [M-1:0] ext_dout;

    int checks;
    int failures;
    logic [M-1:0] rf_model [8];

    field_arith_unit dut (
        .clk            (clk),
        .rst            (rst),
        .control_group3 (cg),
        .done_primitive (done_primitive),
        .busy           (busy),
        .ext_we         (ext_we),
        .ext_addr       (ext_addr),
        .ext_din        (ext_din),
        .ext_dout       (ext_dout)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something stalls outside the bounded loops.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference arithmetic straight from f(x) = x^283 + x^12 + x^7 + x^5 + 1.
    function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
        logic [M-1:0] p;
        logic         top;
        p = '0;
        p[12] = 1'b1; p[7] = 1'b1; p[5] = 1'b1; p[0] = 1'b1;
        top = v[M-1];
        v = v << 1;
        if (top) v = v ^ p;
        return v;
    endfunction

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] aa;
        r  = '0;
        aa = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ aa;
            aa = xtime(aa);
        end
        return r;
    endfunction

    function automatic logic [M-1:0] rand_elem();
        logic [287:0] t;
        for (int w = 0; w < 9; w++) t[w*32 +: 32] = $urandom();
        return t[M-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rf(input logic [2:0] addr);
        ext_addr = addr;
        #1;
    endtask

    task automatic ext_write(input logic [2:0] addr, input logic [M-1:0] data);
        ext_we   = 1'b1;
        ext_addr = addr;
        ext_din  = data;
        tick();
        ext_we   = 1'b0;
        rf_model[addr] = data;
    endtask

    // base: 1 = load A, 2 = load B. BasePtSel[3] gets a random junk bit.
    task automatic load_op(input logic [1:0] base, input logic [2:0] addr);
        cg = {1'($urandom_range(0, 1)), addr, base, 2'b00, 1'b0};
        tick();
        cg = '0;
    endtask

    // Start an operation, count BUSY cycles (bounded), then release en_primitive.
    task automatic run_op(input logic [1:0] mode, input logic [2:0] dest,
                          output int cycles, output bit timeout);
        cg = {1'b0, dest, 2'b00, mode, 1'b1};
        tick();
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
        end
        timeout = (cycles >= 100);
        cg = '0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rf_model[i] = '0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy actual=%b required=0", busy);
        end
        checks++;
        if (done_primitive !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_done actual=%b required=0", done_primitive);
        end
        for (int i = 0; i < 8; i++) begin
            read_rf(3'(i));
            checks++;
            if (ext_dout !== '0) begin
                failures++;
                $display("[TB] FAIL reset_rf%0d actual=%h required=0", i, ext_dout);
            end
        end
    endtask

    task automatic test_square_directed();
        int cycles;
        bit to;
        logic [M-1:0] two;
        two = M'(2);
        ext_write(3'd6, two);
        load_op(2'd1, 3'd6);
        run_op(2'd1, 3'd1, cycles, to);
        checks++;
        if (cycles != 1) begin
            failures++;
            $display("[TB] FAIL square_busy_cycles actual=%0d required=1", cycles);
        end
        read_rf(3'd1);
        checks++;
        if (ext_dout !== M'(4)) begin
            failures++;
            $display("[TB] FAIL square_rf1 actual=%h required=4", ext_dout);
        end
        rf_model[1] = M'(4);
        checks++;
        if (done_primitive !== 1'b1) begin
            failures++;
            $display("[TB] FAIL square_done actual=%b required=1", done_primitive);
        end
    endtask

    task automatic test_multiply_directed();
        int cycles;
        bit to;
        logic [M-1:0] a;
        a = '0;
        a[282] = 1'b1;
        ext_write(3'd3, a);
        ext_write(3'd4, M'(2));
        load_op(2'd1, 3'd3);
        load_op(2'd2, 3'd4);
        run_op(2'd0, 3'd7, cycles, to);
        checks++;
        if (cycles != 18 || to) begin
            failures++;
            $display("[TB] FAIL mul_busy_cycles actual=%0d required=18", cycles);
        end
        read_rf(3'd7);
        checks++;
        if (ext_dout !== M'(16'h10A1)) begin
            failures++;
            $display("[TB] FAIL mul_rf7 actual=%h required=10a1", ext_dout);
        end
        rf_model[7] = M'(16'h10A1);
    endtask

    task automatic test_random_ops();
        int cycles;
        bit to;
        int exp_cycles;
        logic [2:0] sa, sb, dst;
        logic [1:0] mode;
        logic [M-1:0] av, bv, expv;
        for (int it = 0; it < 10; it++) begin
            sa   = 3'($urandom_range(0, 7));
            sb   = 3'($urandom_range(0, 7));
            dst  = 3'($urandom_range(0, 7));
            mode = (it < 4) ? 2'd0 : 2'($urandom_range(0, 3));
            ext_write(sa, rand_elem());
            ext_write(sb, rand_elem());
            av = rf_model[sa];
            bv = rf_model[sb];
            load_op(2'd1, sa);
            load_op(2'd2, sb);
            run_op(mode, dst, cycles, to);
            case (mode)
                2'd0:    begin expv = gf_mul(av, bv); exp_cycles = 18; end
                2'd1:    begin expv = gf_mul(av, av); exp_cycles = 1;  end
                default: begin expv = rf_model[dst];  exp_cycles = 1;  end
            endcase
            rf_model[dst] = expv;
            checks++;
            if (cycles != exp_cycles || to) begin
                failures++;
                $display("[TB] FAIL rand_cycles it=%0d mode=%0d actual=%0d required=%0d",
                         it, mode, cycles, exp_cycles);
            end
            read_rf(dst);
            checks++;
            if (ext_dout !== expv) begin
                failures++;
                $display("[TB] FAIL rand_result it=%0d mode=%0d actual=%h required=%h",
                         it, mode, ext_dout, expv);
            end
            checks++;
            if (done_primitive !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rand_done it=%0d actual=%b required=1", it, done_primitive);
            end
        end
        for (int i = 0; i < 8; i++) begin
            read_rf(3'(i));
            checks++;
            if (ext_dout !== rf_model[i]) begin
                failures++;
                $display("[TB] FAIL rand_sweep_rf%0d actual=%h required=%h", i, ext_dout, rf_model[i]);
            end
        end
    endtask

    task automatic test_done_hold();
        int n;
        logic [M-1:0] av;
        av = rand_elem();
        ext_write(3'd3, av);
        load_op(2'd1, 3'd3);
        cg = {1'b0, 3'd4, 2'b00, 2'd1, 1'b1};
        tick();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done_primitive !== 1'b1) begin
                failures++;
                $display("[TB] FAIL hold_no_restart cyc=%0d actual=busy%b_done%b required=busy0_done1",
                         i, busy, done_primitive);
            end
        end
        cg = '0;
        tick();
        checks++;
        if (done_primitive !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_release actual=busy%b_done%b required=busy0_done1",
                     busy, done_primitive);
        end
        cg = {1'b0, 3'd4, 2'b00, 2'd1, 1'b1};
        tick();
        checks++;
        if (done_primitive !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_restart actual=busy%b_done%b required=busy1_done0",
                     busy, done_primitive);
        end
        tick();
        cg = '0;
        tick();
        rf_model[4] = gf_mul(av, av);
        read_rf(3'd4);
        checks++;
        if (ext_dout !== rf_model[4] || done_primitive !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_result actual=%h required=%h", ext_dout, rf_model[4]);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        ext_write(3'd0, rand_elem());
        ext_write(3'd1, rand_elem());
        load_op(2'd1, 3'd0);
        load_op(2'd2, 3'd1);
        cg = {1'b0, 3'd5, 2'b00, 2'd0, 1'b1};
        tick();
        n = 1;
        while (n < 9 && busy === 1'b1) begin
            n++;
            tick();
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_in_busy actual=%b required=1", busy);
        end
        rst = 1'b1;
        cg  = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rf_model[i] = '0;
        checks++;
        if (busy !== 1'b0 || done_primitive !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_flags actual=busy%b_done%b required=busy0_done0",
                     busy, done_primitive);
        end
        for (int i = 0; i < 20; i++) tick();
        read_rf(3'd5);
        checks++;
        if (ext_dout !== '0 || done_primitive !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_dest actual=%h required=0", ext_dout);
        end
    endtask

    task automatic test_ext_collision();
        int n;
        logic [M-1:0] av, bv, old2;
        av = rand_elem();
        bv = rand_elem();
        ext_write(3'd0, av);
        ext_write(3'd1, bv);
        ext_write(3'd2, rand_elem());
        old2 = rf_model[2];
        load_op(2'd1, 3'd0);
        load_op(2'd2, 3'd1);
        cg = {1'b0, 3'd2, 2'b00, 2'd0, 1'b1};
        tick();
        ext_we   = 1'b1;
        ext_addr = 3'd2;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 9) begin
                checks++;
                if (ext_dout !== old2) begin
                    failures++;
                    $display("[TB] FAIL busy_ext_write actual=%h required=%h", ext_dout, old2);
                end
            end
            ext_din = rand_elem();
            tick();
        end
        ext_we = 1'b0;
        cg = '0;
        tick();
        rf_model[2] = gf_mul(av, bv);
        read_rf(3'd2);
        checks++;
        if (ext_dout !== rf_model[2]) begin
            failures++;
            $display("[TB] FAIL writeback_wins actual=%h required=%h", ext_dout, rf_model[2]);
        end
    endtask

    // Fermat inversion driven like the point-op controller would:
    // r = prod_{i=1..282} a^(2^i) = a^(2^283-2) = a^-1.
    task automatic test_inversion();
        int cycles;
        bit to;
        int bad;
        logic [M-1:0] inv_exp;
        bad = 0;
        ext_write(3'd0, M'(2));
        ext_write(3'd1, M'(1));
        for (int i = 1; i < M; i++) begin
            load_op(2'd1, 3'd0);
            run_op(2'd1, 3'd0, cycles, to);
            if (to) bad++;
            load_op(2'd1, 3'd1);
            load_op(2'd2, 3'd0);
            run_op(2'd0, (i == M-1) ? 3'd7 : 3'd1, cycles, to);
            if (to || cycles != 18) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL inv_op_timing actual=%0d required=0", bad);
        end
        inv_exp = '0;
        inv_exp[282] = 1'b1; inv_exp[11] = 1'b1; inv_exp[6] = 1'b1; inv_exp[4] = 1'b1;
        read_rf(3'd7);
        checks++;
        if (ext_dout !== inv_exp) begin
            failures++;
            $display("[TB] FAIL inv_rf7 actual=%h required=%h", ext_dout, inv_exp);
        end
        ext_write(3'd6, M'(2));
        load_op(2'd1, 3'd7);
        load_op(2'd2, 3'd6);
        run_op(2'd0, 3'd5, cycles, to);
        read_rf(3'd5);
        checks++;
        if (ext_dout !== M'(1)) begin
            failures++;
            $display("[TB] FAIL inv_check_product actual=%h required=1", ext_dout);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        cg       = '0;
        ext_we   = 1'b0;
        ext_addr = '0;
        ext_din  = '0;
        test_reset();
        test_square_directed();
        test_multiply_directed();
        test_random_ops();
        test_done_hold();
        test_ext_collision();
        test_reset_abort();
        test_inversion();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
